muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations. It sits beside the combinational ALU in the execute stage. It accepts one operation per valid/ready handshake and computes it over multiple cycles with a radix-2 shift-add / restoring-division datapath. It returns the result through a second valid/ready handshake, so execute can stall on it.

Parameters:
WordSize, 32, operand and result width in bits (even, >= 4)
CntWidth, $clog2(WordSize)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
muldiv_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  WordSize  rs1 operand (multiplicand / dividend)
b  input  WordSize  rs2 operand (multiplier / divisor)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WordSize  operation result

Behaviour:
- Reset (rstn low, async): state IDLE; out_valid=0; result=0; in_ready=1 after release; counter and internal registers cleared. Reset mid-operation discards the op; no result is produced.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE).
- Accept: in_valid & in_ready at a rising edge latches op, a, b.
  - Signedness: a is signed for MULH/MULHSU/DIV/REM. b is signed for MULH/DIV/REM. MUL low word is sign-agnostic.
  - Signed operands are converted to magnitudes and the result sign is recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Special cases are decided at accept and go IDLE->DONE directly, with out_valid high one cycle after accept:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most-negative, b = -1, DIV/REM): DIV gives a; REM gives 0.
- CALC: exactly WordSize cycles with counter WordSize-1 down to 0.
  - Multiply: 2*WordSize accumulator, shift-add one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle; the remainder is held in a WordSize+1-bit register.
- FIX: one cycle. Applies two's-complement negation per the recorded sign, then selects the output word:
  - MUL: low WordSize bits.
  - MULH*: high WordSize bits.
  - DIV*: quotient.
  - REM*: remainder.
  - The result register is loaded.
- Latency: out_valid rises WordSize+2 cycles after the accept edge (34 for WordSize=32).
- DONE: out_valid=1. result is stable until out_valid & out_ready; on that edge the unit returns to IDLE and out_valid drops.
  - in_ready is 0 in DONE, so there is no back-to-back overlap.
  - The earliest next accept is the cycle after the result handshake.
- Backpressure: out_ready low holds DONE indefinitely; result and out_valid do not change.
- flush (sync, highest priority after reset): any state -> IDLE next edge; out_valid=0.
  - A flush coinciding with an accept or a result handshake wins: the op is dropped.
- in_valid while not ready is ignored; operands need not be held.
- All arithmetic is modulo 2^WordSize per output word. No X propagation: the result holds its last value in IDLE/CALC/FIX.

Test Plan:
1. WordSize=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
2. DIV a=0xFFFFFFF9(-7) b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100 b=7 -> 14; REMU -> 2.
3. DIVU a=0x1234 b=0 -> 0xFFFFFFFF and REMU -> 0x1234, each out_valid 1 cycle after accept; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM -> 0, 1-cycle latency.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1, a new op is accepted the following edge.
5. Assert flush at CALC cycle 10 -> IDLE next edge, out_valid never rises; the next op (MUL 3*5) returns 15 with normal latency.
6. Drop rstn mid-CALC -> out_valid=0 and result=0 immediately (async); after release in_ready=1 and a fresh DIVU 9/3 returns 3.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master issues operations and accepts results; the slave is the unit itself.
interface muldiv_unit_if #(
  parameter int unsigned WordSize = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          muldiv_op;
  logic [WordSize-1:0] a;
  logic [WordSize-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic [WordSize-1:0] result;

  modport master (
    output in_valid,
    output muldiv_op,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  muldiv_op,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring division on operand magnitudes, with the
// result sign applied in a final fix-up cycle. One operation in flight at a time.
module muldiv_unit #(
  parameter int unsigned WordSize = 32,
  parameter int unsigned CntWidth = $clog2(WordSize) + 1
) (
  input logic          clk,
  input logic          rstn,
  input logic          flush,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W = WordSize;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Op encodings (bit 2 = divide family, bit 1 within divide = remainder)
  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  // Multiply: {high, low} product accumulator, multiplier shifts out of the low end.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*W-1:0]      acc_q, acc_d;
  logic [W:0]          rem_q, rem_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [W-1:0]        opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [W-1:0]        result_q, result_d;

  // Accept-time operand decode
  logic         a_signed, b_signed;
  logic         sign_a, sign_b;
  logic         is_div, div_zero, div_ovf;
  logic [W-1:0] mag_a, mag_b;
  logic [W-1:0] special_res;
  logic         op_neg;

  // Decode signedness, magnitudes, result sign and the divide special cases
  always_comb begin
    a_signed = (bus.muldiv_op == OpMulh) || (bus.muldiv_op == OpMulhsu) ||
               (bus.muldiv_op == OpDiv)  || (bus.muldiv_op == OpRem);
    b_signed = (bus.muldiv_op == OpMulh) || (bus.muldiv_op == OpDiv) ||
               (bus.muldiv_op == OpRem);
    sign_a   = a_signed & bus.a[W-1];
    sign_b   = b_signed & bus.b[W-1];
    mag_a    = sign_a ? -bus.a : bus.a;
    mag_b    = sign_b ? -bus.b : bus.b;
    is_div   = bus.muldiv_op[2];
    div_zero = is_div && (bus.b == '0);
    // Only the signed variants (op bit 0 clear) can overflow
    div_ovf  = is_div && !bus.muldiv_op[0] &&
               (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);
    if (div_zero) begin
      special_res = bus.muldiv_op[1] ? bus.a : '1;
    end else begin
      special_res = bus.muldiv_op[1] ? '0 : bus.a;
    end
    // Remainder takes the dividend's sign; product and quotient take sa^sb
    op_neg = (is_div && bus.muldiv_op[1]) ? sign_a : (sign_a ^ sign_b);
  end

  // One datapath iteration for each family
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W+1:0]   rem_sh, rem_diff;
  logic           div_ge;
  logic [W:0]     rem_next;
  logic [W-1:0]   quo_next;

  // Shift-add step and restoring-division step
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    rem_sh   = {rem_q, acc_q[W-1]};
    rem_diff = rem_sh - {2'b00, opb_q};
    // No borrow out of the trial subtraction means the divisor fits
    div_ge   = ~rem_diff[W+1];
    rem_next = div_ge ? rem_diff[W:0] : rem_sh[W:0];
    quo_next = {acc_q[W-2:0], div_ge};
  end

  // Fix-up: apply the recorded sign and pick the output word
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   div_raw, div_s;
  logic [W-1:0]   fix_res;

  // Sign correction and output-word selection
  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    div_raw = op_q[1] ? rem_q[W-1:0] : acc_q[W-1:0];
    div_s   = neg_q ? -div_raw : div_raw;
    if (op_q[2]) begin
      fix_res = div_s;
    end else if (op_q == OpMul) begin
      fix_res = prod_s[W-1:0];
    end else begin
      fix_res = prod_s[2*W-1:W];
    end
  end

  // Next-state logic for the control FSM and datapath registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d  = bus.muldiv_op;
          neg_d = op_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
            cnt_d   = CntWidth'(W - 1);
            rem_d   = '0;
            if (is_div) begin
              acc_d = {{W{1'b0}}, mag_a};
              opb_d = mag_b;
            end else begin
              acc_d = {{W{1'b0}}, mag_b};
              opb_d = mag_a;
            end
          end
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          acc_d = {acc_q[2*W-1:W], quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q - CntWidth'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides any accept or handshake on the same edge; the result is not touched
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases plus randomized operations checked every
// cycle against a transaction-level reference model.
module tb_muldiv_unit;

  localparam int unsigned W       = 32;
  localparam int          LatCalc = W + 2;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;

  muldiv_unit_if #(.WordSize(W)) bus ();

  muldiv_unit #(.WordSize(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          ai, bi;
    longint      sa, sb, ub, q;
    logic [63:0] p;
    ai = a;
    bi = b;
    sa = ai;
    sb = bi;
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Transaction-level model: busy flag, expected result and the cycle it must appear
  bit          m_busy     = 1'b0;
  int          m_valid_at = 0;
  logic [31:0] m_exp      = '0;
  logic [31:0] m_last     = '0;
  bit          m_vld;

  // Compare DUT outputs against the model each cycle, then predict the next edge
  always @(negedge clk) begin
    if (!rstn) begin
      m_busy = 1'b0;
      m_last = '0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
    end else begin
      m_vld = m_busy && (cyc >= m_valid_at);
      if (m_vld) m_last = m_exp;
      chk("in_ready", bus.in_ready, !m_busy);
      chk("out_valid", bus.out_valid, m_vld);
      chk("result", bus.result, m_last);
      if (flush) begin
        m_busy = 1'b0;
      end else if (m_vld && bus.out_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && bus.in_valid) begin
        m_busy     = 1'b1;
        m_exp      = ref_result(bus.muldiv_op, bus.a, bus.b);
        m_valid_at = cyc + 1 + (ref_special(bus.muldiv_op, bus.a, bus.b) ? 0 : W + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until the edge that accepts it
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!bus.in_ready && g < 100) begin step(); g++; end
    bus.in_valid  = 1'b1;
    bus.muldiv_op = op;
    bus.a         = a;
    bus.b         = b;
    step();
    bus.in_valid  = 1'b0;
    bus.muldiv_op = 3'($urandom);
    bus.a         = $urandom;
    bus.b         = $urandom;
  endtask

  // Cycles from the accept edge until out_valid, counting the accept cycle as 1
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin step(); lat++; end
  endtask

  task automatic finish_op(input bit rand_bp);
    bit r;
    int g = 0;
    do begin
      r = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (g >= 20) r = 1'b1;
      bus.out_ready = r;
      step();
      g++;
    end while (!r);
    bus.out_ready = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit rand_bp);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, bus.result, exp);
    finish_op(rand_bp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests,
               n_fail);
      $fatal(1, "watchdog");
    end
  end

  initial begin
    int          lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.muldiv_op = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Pin the reference model on hand-computed values
    chk("pin_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_rem_ovf", ref_result(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_result", bus.result, 0);

    // Multiply
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LatCalc, 1'b0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatCalc, 1'b0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LatCalc, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LatCalc, 1'b0);

    // Divide
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LatCalc, 1'b0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LatCalc, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, LatCalc, 1'b0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, LatCalc, 1'b0);

    // Special cases resolve one cycle after accept
    run_op("divu_zero", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_zero", 3'd7, 32'h1234, 32'd0, 32'h1234, 1, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

    // Backpressure holds DONE; the next op is accepted right after the handshake
    bus.out_ready = 1'b0;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    chk("bp_lat", lat, LatCalc);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_result", bus.result, 32'hFFFF_FFFE);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_out_valid", bus.out_valid, 0);
    bus.in_valid  = 1'b1;
    bus.muldiv_op = 3'd5;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_accepted", bus.in_ready, 0);
    wait_valid(lat);
    chk("bp_next_lat", lat, LatCalc);
    chk("bp_next_res", bus.result, 32'd14);
    finish_op(1'b0);

    // Flush mid-calculation drops the op
    issue(3'd0, 32'd123, 32'd456);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    repeat (40) step();
    chk("flush_no_result", bus.out_valid, 0);
    run_op("after_flush", 3'd0, 32'd3, 32'd5, 32'd15, LatCalc, 1'b0);

    // Asynchronous reset mid-calculation
    issue(3'd5, 32'd1000, 32'd7);
    repeat (5) step();
    rstn = 1'b0;
    #1;
    chk("areset_out_valid", bus.out_valid, 0);
    chk("areset_result", bus.result, 0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("areset_in_ready", bus.in_ready, 1);
    run_op("after_reset", 3'd5, 32'd9, 32'd3, 32'd3, LatCalc, 1'b0);

    // Randomized operations with random result backpressure
    for (int i = 0; i < 250; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op("rand", rop, ra, rb, ref_result(rop, ra, rb),
             ref_special(rop, ra, rb) ? 1 : LatCalc, 1'b1);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
